// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the program counter, fetches one word at a time
// from a variable-latency instruction memory over a req/ack handshake, buffers
// it, and presents it on the ir bus when ctrl asks for it. Redirects squash any
// fetch whose address has become stale.
module inst_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              fetch_en,
  input  logic              pc_write,
  input  logic              pc_sel,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic              ir_load,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [DATA_W-1:0] im_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } fetchState_t;

  fetchState_t       state;
  fetchState_t       stateNext;
  logic              stale;
  logic [DATA_W-1:0] bufWord;

  logic [ADDR_W-1:0] pcNext;
  logic              redirect;
  logic              loadAddr;
  logic              loadBuf;
  logic              loadIr;
  logic              setStale;
  logic              clrStale;

  // Next PC: increment wraps naturally at the top of the address space.
  always_comb begin
    pcNext   = pc;
    redirect = pc_write && pc_sel;
    if (pc_write) begin
      pcNext = pc_sel ? br_addr : pc + ADDR_W'(1);
    end
  end

  // Next-state and datapath-enable decode for the fetch FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    stateNext = state;
    loadAddr  = 1'b0;
    loadBuf   = 1'b0;
    loadIr    = 1'b0;
    setStale  = 1'b0;
    clrStale  = 1'b0;
    unique case (state)
      IDLE: begin
        // An ack arriving here belongs to nothing we asked for; ignore it.
        if (fetch_en) begin
          loadAddr  = 1'b1;
          stateNext = REQ;
        end
      end
      REQ: begin
        if (im_ack) begin
          if (!stale && !redirect) begin
            loadBuf   = 1'b1;
            stateNext = FULL;
          end else begin
            // Data is for an abandoned address: re-issue at the new PC at once.
            loadAddr = 1'b1;
            clrStale = 1'b1;
          end
        end else if (redirect) begin
          setStale = 1'b1;
        end
      end
      FULL: begin
        if (ir_load) begin
          // A simultaneous redirect still lets the buffered word through.
          loadIr    = 1'b1;
          stateNext = IDLE;
        end else if (redirect) begin
          stateNext = IDLE;
        end
        if ((ir_load || redirect) && fetch_en) begin
          loadAddr  = 1'b1;
          stateNext = REQ;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, PC and fetch-address registers.
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      im_addr <= '0;
      stale   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state <= stateNext;
      pc    <= pcNext;
      if (loadAddr) im_addr <= pcNext;
      if (setStale)      stale <= 1'b1;
      else if (clrStale) stale <= 1'b0;
    end
  end

  // Fetched-word buffer and the instruction register it feeds.
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      bufWord  <= '0;
      ir       <= '0;
      ir_valid <= 1'b0;
    end else begin
      if (loadBuf) bufWord <= im_rdata;
      if (loadIr)  ir      <= bufWord;
      ir_valid <= loadIr;
    end
  end

  assign im_req = (state == REQ);
  assign busy   = (state == REQ);

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the fetch stage.
module tb_inst_fetch;

  logic        clk;
  logic        rst_f;
  logic        fetch_en;
  logic        pc_write;
  logic        pc_sel;
  logic [15:0] br_addr;
  logic        ir_load;
  logic        im_req;
  logic [15:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [15:0] pc;
  logic [31:0] ir;
  logic        ir_valid;
  logic        busy;

  int compared;
  int mismatched;

  // Reference model: an outstanding request (address, invalidated flag), an
  // optional buffered word, the PC and the instruction register.
  bit          mReq;
  bit          mStale;
  logic [15:0] mAddr;
  bit          mFull;
  logic [31:0] mBuf;
  logic [15:0] mPc;
  logic [31:0] mIr;
  bit          mIrValid;

  inst_fetch #(.ADDR_W(16), .DATA_W(32), .RESET_PC(16'h0000)) dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .fetch_en (fetch_en),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .br_addr  (br_addr),
    .ir_load  (ir_load),
    .im_req   (im_req),
    .im_addr  (im_addr),
    .im_ack   (im_ack),
    .im_rdata (im_rdata),
    .pc       (pc),
    .ir       (ir),
    .ir_valid (ir_valid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents.
  function automatic logic [31:0] memWord(input logic [15:0] a);
    case (a)
      16'h0000: return 32'hA000_0001;
      16'h0001: return 32'hB000_0002;
      16'h0002: return 32'hC000_0003;
      default:  return {a ^ 16'h5A5A, ~a};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mReq = 0; mStale = 0; mAddr = '0; mFull = 0;
    mBuf = '0; mPc = '0; mIr = '0; mIrValid = 0;
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".pc"},       32'(pc),       32'(mPc));
    check({tag, ".im_req"},   32'(im_req),   32'(mReq));
    check({tag, ".busy"},     32'(busy),     32'(mReq));
    check({tag, ".im_addr"},  32'(im_addr),  32'(mAddr));
    check({tag, ".ir"},       ir,            mIr);
    check({tag, ".ir_valid"}, 32'(ir_valid), 32'(mIrValid));
  endtask

  // One clock: starts at a negedge, drives inputs, advances the model, then
  // compares at the following negedge.
  task automatic cycle(input string tag, input bit fe, input bit pw, input bit ps,
                       input logic [15:0] ba, input bit il, input bit ack);
    logic [15:0] pcN;
    bit          redir;
    bit          wasFull;
    fetch_en = fe; pc_write = pw; pc_sel = ps; br_addr = ba;
    ir_load = il; im_ack = ack;
    im_rdata = ack ? memWord(mAddr) : $urandom;

    pcN     = pw ? (ps ? ba : mPc + 16'd1) : mPc;
    redir   = pw && ps;
    wasFull = mFull;
    mIrValid = 0;
    if (mReq) begin
      if (ack) begin
        if (!mStale && !redir) begin
          mBuf = im_rdata; mFull = 1; mReq = 0;
        end else begin
          mAddr = pcN; mStale = 0;
        end
      end else if (redir) begin
        mStale = 1;
      end
    end else if (wasFull) begin
      if (il) begin
        mIr = mBuf; mIrValid = 1;
      end
      if (il || redir) begin
        mFull = 0;
        if (fe) begin mReq = 1; mAddr = pcN; end
      end
    end else if (fe) begin
      mReq = 1; mAddr = pcN;
    end
    mPc = pcN;

    @(posedge clk);
    @(negedge clk);
    checkAll(tag);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_f = 1'b1; fetch_en = 0; pc_write = 0; pc_sel = 0; br_addr = '0;
    ir_load = 0; im_ack = 0; im_rdata = '0;
    modelReset();
    #2;
    checkAll("reset");
    @(negedge clk);
    rst_f = 1'b0;

    // Async reset mid-request, after one instruction has been loaded.
    cycle("r.fe",   1, 0, 0, 16'h0, 0, 0);
    cycle("r.ack",  0, 0, 0, 16'h0, 0, 1);
    cycle("r.ld",   0, 1, 0, 16'h0, 1, 0);
    check("r.ir_before", ir, 32'hA000_0001);
    cycle("r.fe2",  1, 0, 0, 16'h0, 0, 0);
    check("r.req_before", 32'(im_req), 32'd1);
    #2 rst_f = 1'b1;
    #1;
    check("r.async_req",  32'(im_req), 32'd0);
    check("r.async_busy", 32'(busy),   32'd0);
    check("r.async_pc",   32'(pc),     32'd0);
    check("r.async_ir",   ir,          32'd0);
    modelReset();
    @(negedge clk);
    rst_f = 1'b0;
    cycle("r.lateack", 0, 0, 0, 16'h0, 0, 1);

    // Sequential fetch with single-cycle memory, back-to-back issue on load.
    cycle("s.fe", 1, 0, 0, 16'h0, 0, 0);
    check("s.addr0", 32'(im_addr), 32'h0);
    cycle("s.ack0", 0, 0, 0, 16'h0, 0, 1);
    cycle("s.ld0",  1, 1, 0, 16'h0, 1, 0);
    check("s.ir0", ir, 32'hA000_0001);
    check("s.addr1", 32'(im_addr), 32'h1);
    cycle("s.ack1", 0, 0, 0, 16'h0, 0, 1);
    cycle("s.ld1",  1, 1, 0, 16'h0, 1, 0);
    check("s.ir1", ir, 32'hB000_0002);
    check("s.addr2", 32'(im_addr), 32'h2);
    cycle("s.ack2", 0, 0, 0, 16'h0, 0, 1);
    cycle("s.ld2",  0, 1, 0, 16'h0, 1, 0);
    check("s.ir2", ir, 32'hC000_0003);
    check("s.pc3", 32'(pc), 32'h3);

    // Wait states: three cycles without ack.
    cycle("w.fe", 1, 0, 0, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle("w.wait", 0, 0, 0, 16'h0, 0, 0);
      check("w.req_held",  32'(im_req),  32'd1);
      check("w.addr_held", 32'(im_addr), 32'h3);
      check("w.ir_held",   ir,           32'hC000_0003);
    end
    cycle("w.ack", 0, 0, 0, 16'h0, 0, 1);
    check("w.ir_not_early", ir, 32'hC000_0003);
    cycle("w.ld",  0, 0, 0, 16'h0, 1, 0);
    check("w.ir", ir, memWord(16'h3));

    // Redirect while a request is outstanding.
    cycle("b.jmp5",  0, 1, 1, 16'h0005, 0, 0);
    cycle("b.fe",    1, 0, 0, 16'h0, 0, 0);
    check("b.addr5", 32'(im_addr), 32'h5);
    cycle("b.jmp40", 0, 1, 1, 16'h0040, 0, 0);
    cycle("b.stale", 0, 0, 0, 16'h0, 0, 1);
    check("b.rereq", 32'(im_req), 32'd1);
    check("b.addr40", 32'(im_addr), 32'h40);
    cycle("b.ack",   0, 0, 0, 16'h0, 0, 1);
    cycle("b.ld",    0, 0, 0, 16'h0, 1, 0);
    check("b.ir", ir, memWord(16'h40));

    // Redirect colliding with ack, then redirect in FULL without load.
    cycle("c.fe",    1, 0, 0, 16'h0, 0, 0);
    cycle("c.coll",  0, 1, 1, 16'h0010, 0, 1);
    check("c.addr10", 32'(im_addr), 32'h10);
    check("c.still_req", 32'(im_req), 32'd1);
    cycle("c.ack",   0, 0, 0, 16'h0, 0, 1);
    cycle("c.drop",  0, 1, 1, 16'h0020, 0, 0);
    check("c.idle", 32'(im_req), 32'd0);
    cycle("c.bubble", 0, 0, 0, 16'h0, 1, 0);
    check("c.bubble_valid", 32'(ir_valid), 32'd0);
    check("c.bubble_ir", ir, memWord(16'h40));

    // PC wrap.
    cycle("p.jmp", 0, 1, 1, 16'hFFFF, 0, 0);
    cycle("p.inc", 0, 1, 0, 16'h0, 0, 0);
    check("p.wrap", 32'(pc), 32'h0);
    cycle("p.fe",  1, 0, 0, 16'h0, 0, 0);
    check("p.addr0", 32'(im_addr), 32'h0);
    cycle("p.ack", 0, 0, 0, 16'h0, 0, 1);
    cycle("p.ld",  0, 0, 0, 16'h0, 1, 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit          fe, pw, ps, il, ack;
      logic [15:0] ba;
      fe  = ($urandom_range(0, 3) != 0);
      pw  = ($urandom_range(0, 2) == 0);
      ps  = ($urandom_range(0, 2) == 0);
      il  = ($urandom_range(0, 1) == 1);
      ba  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      ack = (mReq || !mFull) ? ($urandom_range(0, 2) == 0) : 1'b0;
      cycle("rand", fe, pw, ps, ba, il, ack);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
